// File: rtl/chorus_pkg.sv
// Shared constants and FSM state type for the chorus LFO controller.
package chorus_pkg;

  localparam int COS_W   = 17;
  localparam int PHASE_W = 16;
  localparam int FRAC_W  = 8;

  // Field widths of the depth and (default) centre settings
  localparam int DEPTH_W  = 8;
  localparam int CENTER_W = 10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PHASE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_SCALE   = 3'd3,
    S_OUT     = 3'd4
  } lfo_state_t;

endpackage

// File: rtl/chorus_phase_acc.sv
// Phase accumulator for the chorus LFO: presents the pre-increment phase to
// the cosine block, then steps by the increment latched with the strobe.
module chorus_phase_acc
  import chorus_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [ACC_W-1:0]   freq_word,
  output logic [PHASE_W-1:0] cos_phase
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] freq_q;

  // Latch increment and publish current phase on load; advance one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      freq_q    <= '0;
      cos_phase <= '0;
    end else if (load) begin
      freq_q    <= freq_word;
      cos_phase <= acc[ACC_W-1 -: PHASE_W];
    end else if (step) begin
      acc <= acc + freq_q;
    end
  end

endmodule

// File: rtl/chorus_lfo_ctrl.sv
// Per-sample chorus LFO controller: phase step, cosine capture, depth scaling
// and clamped fractional delay output.
module chorus_lfo_ctrl
  import chorus_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int DELAY_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic [ACC_W-1:0]        freq_word,
  input  logic [DEPTH_W-1:0]      depth,
  input  logic [DELAY_W-1:0]      center,
  output logic [PHASE_W-1:0]      cos_phase,
  input  logic signed [COS_W-1:0] cos_value,
  output logic [DELAY_W-1:0]      delay_int,
  output logic [FRAC_W-1:0]       delay_frac,
  output logic                    delay_valid,
  output logic                    busy,
  output logic                    clamped,
  output logic                    overrun
);

  localparam int SUM_W  = DELAY_W + 10;
  localparam int PROD_W = COS_W + DEPTH_W + 1;

  lfo_state_t state;
  logic accept;

  logic [DEPTH_W-1:0]      depth_q;
  logic [DELAY_W-1:0]      center_q;
  logic signed [COS_W-1:0] cos_q;

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] prod_sh;
  logic signed [SUM_W-1:0]  center_ext;
  logic signed [SUM_W-1:0]  sum;
  logic                     sat_lo;
  logic                     sat_hi;
  logic [DELAY_W-1:0]       next_int;
  logic [FRAC_W-1:0]        next_frac;

  assign accept = (state == S_IDLE) && sample_en;
  assign busy   = (state != S_IDLE);

  chorus_phase_acc #(
    .ACC_W(ACC_W)
  ) u_phase_acc (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (state == S_PHASE),
    .freq_word (freq_word),
    .cos_phase (cos_phase)
  );

  // Scale the captured cosine by depth, add the Q.8 centre and saturate
  always_comb begin
    prod       = PROD_W'(cos_q) * PROD_W'($signed({1'b0, depth_q}));
    prod_sh    = prod >>> 7;
    center_ext = SUM_W'({center_q, FRAC_W'(0)});
    sum        = center_ext + SUM_W'(prod_sh);
    sat_lo     = sum[SUM_W-1];
    sat_hi     = !sum[SUM_W-1] && (|sum[SUM_W-2:DELAY_W+FRAC_W]);
    next_int   = sum[DELAY_W+FRAC_W-1:FRAC_W];
    next_frac  = sum[FRAC_W-1:0];
    if (sat_lo) begin
      next_int  = '0;
      next_frac = '0;
    end else if (sat_hi) begin
      next_int  = '1;
      next_frac = '1;
    end
  end

  // Sequencer: latch settings, capture cosine, register the delay result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      depth_q     <= '0;
      center_q    <= '0;
      cos_q       <= '0;
      delay_int   <= '0;
      delay_frac  <= '0;
      delay_valid <= 1'b0;
      clamped     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      delay_valid <= 1'b0;
      if (sample_en && state != S_IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (sample_en) begin
            depth_q  <= depth;
            center_q <= center;
            state    <= S_PHASE;
          end
        end
        S_PHASE: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          cos_q <= cos_value;
          state <= S_SCALE;
        end
        S_SCALE: begin
          delay_int   <= next_int;
          delay_frac  <= next_frac;
          clamped     <= sat_lo || sat_hi;
          delay_valid <= 1'b1;
          state       <= S_OUT;
        end
        S_OUT: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chorus_lfo_ctrl.sv
// Directed bench for chorus_lfo_ctrl with hand-computed expected delays.
module tb_chorus_lfo_ctrl;

  logic               clk;
  logic               rst;
  logic               sample_en;
  logic [31:0]        freq_word;
  logic [7:0]         depth;
  logic [9:0]         center;
  logic [15:0]        cos_phase;
  logic signed [16:0] cos_value;
  logic [9:0]         delay_int;
  logic [7:0]         delay_frac;
  logic               delay_valid;
  logic               busy;
  logic               clamped;
  logic               overrun;

  int          compared;
  int          mismatched;
  logic [31:0] exp_acc;
  logic [15:0] last_phase;

  chorus_lfo_ctrl #(
    .ACC_W   (32),
    .DELAY_W (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (sample_en),
    .freq_word   (freq_word),
    .depth       (depth),
    .center      (center),
    .cos_phase   (cos_phase),
    .cos_value   (cos_value),
    .delay_int   (delay_int),
    .delay_frac  (delay_frac),
    .delay_valid (delay_valid),
    .busy        (busy),
    .clamped     (clamped),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one strobe and follow it through to the delay_valid pulse
  task automatic apply_stimulus(input string tag, input logic [31:0] fw, input logic [7:0] dp,
                                input logic [9:0] cn, input int cv, input logic [9:0] exp_int,
                                input logic [7:0] exp_frac, input logic exp_clamp);
    logic [15:0] exp_ph;
    freq_word = fw;
    depth     = dp;
    center    = cn;
    cos_value = 17'(cv);
    sample_en = 1'b1;
    exp_ph    = exp_acc[31:16];
    exp_acc   = exp_acc + fw;
    tick();
    sample_en = 1'b0;
    freq_word = 32'hDEAD_BEEF;
    depth     = 8'hFF;
    center    = 10'h000;
    check_output({tag, "_phase"}, 32'(cos_phase), 32'(exp_ph));
    check_output({tag, "_busy1"}, 32'(busy), 32'd1);
    last_phase = exp_ph;
    tick();
    tick();
    tick();
    check_output({tag, "_valid"}, 32'(delay_valid), 32'd1);
    check_output({tag, "_int"}, 32'(delay_int), 32'(exp_int));
    check_output({tag, "_frac"}, 32'(delay_frac), 32'(exp_frac));
    check_output({tag, "_clamp"}, 32'(clamped), 32'(exp_clamp));
    check_output({tag, "_busy4"}, 32'(busy), 32'd1);
    tick();
    check_output({tag, "_valid_end"}, 32'(delay_valid), 32'd0);
    check_output({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_acc    = 32'd0;
    last_phase = 16'd0;
    rst        = 1'b1;
    sample_en  = 1'b0;
    freq_word  = 32'd0;
    depth      = 8'd0;
    center     = 10'd512;
    cos_value  = 17'sd0;

    $display("[TB] reset");
    tick();
    tick();
    check_output("rst_phase", 32'(cos_phase), 32'd0);
    check_output("rst_int", 32'(delay_int), 32'd0);
    check_output("rst_frac", 32'(delay_frac), 32'd0);
    check_output("rst_valid", 32'(delay_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_clamp", 32'(clamped), 32'd0);
    check_output("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] depth zero passes centre");
    apply_stimulus("t1", 32'h0, 8'd0, 10'd512, -32768, 10'd512, 8'd0, 1'b0);
    tick();

    $display("[TB] phase stepping with wrap");
    for (int i = 0; i < 5; i++) begin
      apply_stimulus("t2", 32'h4000_0000, 8'd0, 10'd300, 12345, 10'd300, 8'd0, 1'b0);
      tick();
      tick();
    end
    check_output("t2_wrap_phase", 32'(last_phase), 32'h0000);
    check_output("t2_overrun", 32'(overrun), 32'd0);

    $display("[TB] depth scaling");
    apply_stimulus("t3_pos", 32'h0, 8'd100, 10'd512, 32768, 10'd612, 8'd0, 1'b0);
    apply_stimulus("t3_neg", 32'h0, 8'd100, 10'd512, -32768, 10'd412, 8'd0, 1'b0);
    apply_stimulus("t3_half", 32'h0, 8'd100, 10'd512, 16384, 10'd562, 8'd0, 1'b0);
    apply_stimulus("t3_one", 32'h0, 8'd100, 10'd512, 1, 10'd512, 8'd0, 1'b0);
    apply_stimulus("t3_fpos", 32'h0, 8'd100, 10'd512, 1000, 10'd515, 8'd13, 1'b0);
    apply_stimulus("t3_fneg", 32'h0, 8'd100, 10'd512, -1000, 10'd508, 8'd242, 1'b0);

    $display("[TB] saturation");
    apply_stimulus("t4_lo", 32'h0, 8'd100, 10'd50, -32768, 10'd0, 8'd0, 1'b1);
    apply_stimulus("t4_hi", 32'h0, 8'd100, 10'd1000, 32768, 10'd1023, 8'd255, 1'b1);
    apply_stimulus("t4_edge", 32'h0, 8'd0, 10'd1023, 32768, 10'd1023, 8'd0, 1'b0);

    $display("[TB] strobe while busy");
    freq_word = 32'h1000_0000;
    depth     = 8'd0;
    center    = 10'd200;
    cos_value = 17'sd0;
    sample_en = 1'b1;
    last_phase = exp_acc[31:16];
    exp_acc   = exp_acc + 32'h1000_0000;
    tick();
    sample_en = 1'b0;
    check_output("t5_phase", 32'(cos_phase), 32'(last_phase));
    tick();
    freq_word = 32'hFFFF_FFFF;
    center    = 10'd7;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    check_output("t5_overrun_set", 32'(overrun), 32'd1);
    check_output("t5_no_valid_early", 32'(delay_valid), 32'd0);
    tick();
    check_output("t5_valid", 32'(delay_valid), 32'd1);
    check_output("t5_int", 32'(delay_int), 32'd200);
    tick();
    check_output("t5_single_valid", 32'(delay_valid), 32'd0);
    check_output("t5_overrun_hold", 32'(overrun), 32'd1);
    tick();
    apply_stimulus("t5_next", 32'h1000_0000, 8'd0, 10'd201, 0, 10'd201, 8'd0, 1'b0);
    check_output("t5_overrun_sticky", 32'(overrun), 32'd1);

    $display("[TB] reset mid-operation");
    freq_word = 32'h0200_0000;
    depth     = 8'd0;
    center    = 10'd900;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_output("t6_busy", 32'(busy), 32'd0);
    check_output("t6_phase", 32'(cos_phase), 32'd0);
    check_output("t6_int", 32'(delay_int), 32'd0);
    check_output("t6_frac", 32'(delay_frac), 32'd0);
    check_output("t6_valid", 32'(delay_valid), 32'd0);
    check_output("t6_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    exp_acc = 32'd0;
    tick();
    check_output("t6_no_valid1", 32'(delay_valid), 32'd0);
    tick();
    check_output("t6_no_valid2", 32'(delay_valid), 32'd0);
    tick();
    apply_stimulus("t6_after", 32'h0800_0000, 8'd0, 10'd64, 0, 10'd64, 8'd0, 1'b0);

    $display("[TB] strobe during OUT cycle");
    freq_word = 32'h0800_0000;
    depth     = 8'd0;
    center    = 10'd77;
    sample_en = 1'b1;
    last_phase = exp_acc[31:16];
    exp_acc   = exp_acc + 32'h0800_0000;
    tick();
    sample_en = 1'b0;
    check_output("t7_phase", 32'(cos_phase), 32'(last_phase));
    tick();
    tick();
    tick();
    sample_en = 1'b1;
    check_output("t7_valid", 32'(delay_valid), 32'd1);
    tick();
    sample_en = 1'b0;
    check_output("t7_ignored_busy", 32'(busy), 32'd0);
    check_output("t7_overrun", 32'(overrun), 32'd1);
    check_output("t7_phase_hold", 32'(cos_phase), 32'(last_phase));
    tick();
    check_output("t7_no_valid", 32'(delay_valid), 32'd0);
    apply_stimulus("t7_next", 32'h0800_0000, 8'd0, 10'd78, 0, 10'd78, 8'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
